mem_access_unit: RTL and testbench

//  MEM-stage load/store engine; consumes memory controls from the decoder (memwrite, memtoreg,

---
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a word-wide data-memory bus.
// Ports:
//   clk, reset           clock (rising edge) and asynchronous active-high reset
//   req_valid/req_ready  request handshake from EX/MEM; ready only while idle
//   memwrite, size,      store/load select, access size (01 byte, 10 half, 11 word, 00 no-op),
//   lunsigned            zero-extend for lbu/lhu
//   addr, wdata          byte address and right-justified store data
//   busy                 pipeline stall, high whenever an access is in progress
//   resp_valid, rdata,   one-cycle completion pulse with extended load data and
//   misalign_err         misalignment flag
//   bus_req/bus_we/...   data-memory bus: word address, byte enables, lane-aligned data,
//   bus_ack, bus_rdata   ack completes a beat, read data valid with ack
// Build option: define MEM_MISALIGN_SPLIT_EN to split misaligned accesses into two bus beats;
// otherwise a misaligned access skips the bus and responds with misalign_err.
module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          memwrite,
  input  logic [1:0]    size,
  input  logic          lunsigned,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          resp_valid,
  output logic [DW-1:0] rdata,
  output logic          misalign_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUS0, BUS1, RESP} state_t;
  state_t          r_state, w_next;
  logic            r_we, r_uns, r_err;
  logic [1:0]      r_size;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata, r_beat0, r_rdata;
  logic            w_accept, w_in_err, w_in_skip, w_split, w_last_ack;
  logic [1:0]      w_off;
  logic [3:0]      w_nmask;
  logic [6:0]      w_mask;
  logic [AW-1:0]   w_base;
  logic [2*DW-1:0] w_wide;
  logic [DW-1:0]   w_merge, w_ext;
`ifdef MEM_MISALIGN_SPLIT_EN
  assign w_in_err = 1'b0;
`else
  assign w_in_err = (size == 2'b10 && addr[0]) || (size == 2'b11 && addr[1:0] != 2'b00);
`endif
  assign w_accept = req_valid && r_state == IDLE;
  assign w_in_skip = size == 2'b00 || w_in_err;
  assign w_off = r_addr[1:0];
  assign w_nmask = r_size == 2'b01 ? 4'b0001 : r_size == 2'b10 ? 4'b0011 :
                   r_size == 2'b11 ? 4'b1111 : 4'b0000;
  // bits [6:4] are the lanes that spill into the following word
  assign w_mask = {3'b000, w_nmask} << w_off;
  assign w_split = w_mask[6:4] != 3'b000;
  assign w_base = {r_addr[AW-1:2], 2'b00};
  // low half feeds the first beat, high half the spill-over beat
  assign w_wide = {{DW{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_last_ack = bus_ack && ((r_state == BUS0 && !w_split) || r_state == BUS1);
  assign w_merge = DW'((r_state == BUS1 ? {bus_rdata, r_beat0} : {{DW{1'b0}}, bus_rdata})
                       >> {w_off, 3'b000});
  assign w_ext = r_size == 2'b01 ? {{24{w_merge[7] & ~r_uns}}, w_merge[7:0]} :
                 r_size == 2'b10 ? {{16{w_merge[15] & ~r_uns}}, w_merge[15:0]} : w_merge;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = !req_valid ? IDLE : w_in_skip ? RESP : BUS0;
      BUS0:    w_next = !bus_ack ? BUS0 : w_split ? BUS1 : RESP;
      BUS1:    w_next = bus_ack ? RESP : BUS1;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready = r_state == IDLE;
    busy = r_state != IDLE;
    bus_req = r_state == BUS0 || r_state == BUS1;
    bus_we = bus_req && r_we;
    bus_addr = r_state == BUS0 ? w_base : r_state == BUS1 ? w_base + AW'(4) : '0;
    bus_be = r_state == BUS0 ? w_mask[3:0] : r_state == BUS1 ? {1'b0, w_mask[6:4]} : 4'b0000;
    bus_wdata = !bus_we ? '0 : r_state == BUS0 ? w_wide[DW-1:0] : w_wide[2*DW-1:DW];
    resp_valid = r_state == RESP;
    rdata = resp_valid ? r_rdata : '0;
    misalign_err = resp_valid && r_err;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_we <= 1'b0;
      r_uns <= 1'b0;
      r_err <= 1'b0;
      r_size <= 2'b00;
      r_addr <= '0;
      r_wdata <= '0;
      r_beat0 <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we <= memwrite;
        r_uns <= lunsigned;
        r_err <= w_in_err;
        r_size <= size;
        r_addr <= addr;
        r_wdata <= wdata;
        r_rdata <= '0;
      end
      if (r_state == BUS0 && bus_ack) r_beat0 <= bus_rdata;
      if (w_last_ack && !r_we) r_rdata <= w_ext;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store checks against a byte-level memory model.
module tb_mem_access_unit;
`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, memwrite = 1'b0, lunsigned = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = '0, wdata = '0, rdata, bus_addr, bus_wdata, bus_rdata = '0;
  logic busy, resp_valid, misalign_err, bus_req, bus_we, bus_ack = 1'b0;
  logic [3:0] bus_be;
  int total = 0, bad = 0;
  logic [7:0] bmem [1024];
  logic [7:0] mmem [1024];
  int o_lat, o_nb, o_reqcyc;
  bit o_busy_bad;
  logic [31:0] o_addr [2], o_wd [2], o_rd;
  logic [3:0] o_be [2];
  logic o_we [2], o_err;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .memwrite(memwrite), .size(size), .lunsigned(lunsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .resp_valid(resp_valid), .rdata(rdata), .misalign_err(misalign_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    bmem[a[9:0]] = b;
    mmem[a[9:0]] = b;
  endtask

  function automatic logic [31:0] word_at(input bit model, input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      logic [9:0] ix;
      ix = 10'(a + 32'(i));
      w[8*i +: 8] = model ? mmem[ix] : bmem[ix];
    end
    return w;
  endfunction

  // Acts as the memory slave; called just after a falling edge.
  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int w0, input int w1);
    int waits;
    req_valid = 1'b1; memwrite = we; size = sz; lunsigned = uns; addr = a; wdata = wd;
    chk("ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'($urandom); memwrite = 1'($urandom); size = 2'($urandom);
    lunsigned = 1'($urandom); addr = $urandom; wdata = $urandom;
    o_lat = 0; o_nb = 0; o_reqcyc = 0; o_busy_bad = 1'b0; o_rd = 'x; o_err = 1'bx;
    waits = w0;
    for (int c = 1; c <= 40 && o_lat == 0; c++) begin
      if (resp_valid) begin
        o_lat = c; o_rd = rdata; o_err = misalign_err;
      end else begin
        if (!busy) o_busy_bad = 1'b1;
        if (bus_req) begin
          o_reqcyc++;
          if (waits > 0) begin
            waits--; bus_ack = 1'b0; bus_rdata = $urandom;
          end else begin
            if (o_nb < 2) begin
              o_addr[o_nb] = bus_addr; o_be[o_nb] = bus_be; o_wd[o_nb] = bus_wdata; o_we[o_nb] = bus_we;
            end
            bus_rdata = word_at(1'b0, bus_addr);
            if (bus_we)
              for (int l = 0; l < 4; l++)
                if (bus_be[l]) bmem[10'(bus_addr + 32'(l))] = bus_wdata[8*l +: 8];
            bus_ack = 1'b1; o_nb++; waits = w1;
          end
        end else begin
          bus_ack = 1'($urandom); bus_rdata = $urandom;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0; bus_ack = 1'b0;
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input int w0, input int w1);
    int n, off, e_nb, e_lat;
    bit mis, blocked;
    logic [3:0] e_be0, e_be1;
    logic [31:0] v, base;
    n = sz == 2'd1 ? 1 : sz == 2'd2 ? 2 : sz == 2'd3 ? 4 : 0;
    off = int'(a % 4);
    base = a & ~32'd3;
    mis = (n == 2 && a[0]) || (n == 4 && off != 0);
    blocked = n == 0 || (mis && !SPLIT);
    e_nb = blocked ? 0 : (off + n > 4 ? 2 : 1);
    e_lat = blocked ? 1 : 1 + e_nb + w0 + (e_nb == 2 ? w1 : 0);
    e_be0 = '0; e_be1 = '0; v = '0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] b;
      b = a + 32'(i);
      if ((b & ~32'd3) == base) e_be0[b[1:0]] = 1'b1; else e_be1[b[1:0]] = 1'b1;
      v = v | (32'(mmem[b[9:0]]) << (8 * i));
    end
    if (!uns && n == 1 && v[7]) v = v | 32'hFFFF_FF00;
    if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    access(we, sz, uns, a, wd, w0, w1);
    if (!blocked && we)
      for (int i = 0; i < n; i++) mmem[10'(a + 32'(i))] = wd[8*i +: 8];
    chk("latency", 32'(o_lat), 32'(e_lat));
    chk("beats", 32'(o_nb), 32'(e_nb));
    chk("req_cycles", 32'(o_reqcyc), 32'(e_nb == 0 ? 0 : e_nb + w0 + (e_nb == 2 ? w1 : 0)));
    chk("busy", 32'(o_busy_bad), 32'd0);
    chk("rdata", o_rd, (!blocked && !we) ? v : 32'd0);
    chk("misalign_err", 32'(o_err), 32'(mis && !SPLIT));
    if (o_nb >= 1 && e_nb >= 1) begin
      chk("b0_addr", o_addr[0], base);
      chk("b0_be", 32'(o_be[0]), 32'(e_be0));
      chk("b0_we", 32'(o_we[0]), 32'(we));
    end
    if (o_nb >= 2 && e_nb == 2) begin
      chk("b1_addr", o_addr[1], base + 32'd4);
      chk("b1_be", 32'(o_be[1]), 32'(e_be1));
    end
    for (int k = -1; k <= 1; k++)
      chk("mem", word_at(1'b0, base + 32'(4 * k)), word_at(1'b1, base + 32'(4 * k)));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bmem[i] = 8'($urandom);
      mmem[i] = bmem[i];
    end
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus", {bus_addr ^ bus_wdata ^ rdata}, 32'd0);
    chk("rst_be_err", {27'd0, bus_be, misalign_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // lb with sign extension, immediate ack
    poke(32'h100, 8'h00); poke(32'h101, 8'hFF); poke(32'h102, 8'hFF); poke(32'h103, 8'h80);
    run(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 0, 0);
    chk("lb_rdata", o_rd, 32'hFFFF_FF80);
    chk("lb_be", 32'(o_be[0]), 32'b1000);
    chk("lb_lat", 32'(o_lat), 32'd2);
    // sh into upper half
    run(1'b1, 2'b10, 1'b0, 32'h202, 32'h0000_BEEF, 0, 0);
    chk("sh_addr", o_addr[0], 32'h200);
    chk("sh_be", 32'(o_be[0]), 32'b1100);
    chk("sh_wdata", o_wd[0], 32'hBEEF_0000);
    chk("sh_we", 32'(o_we[0]), 32'd1);
    // lhu with three wait cycles
    run(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 3, 0);
    chk("lhu_rdata", o_rd, 32'h0000_FF00);
    chk("lhu_req_cycles", 32'(o_reqcyc), 32'd4);
    // lw straddling a word boundary
    poke(32'h1FC, 8'h34); poke(32'h1FD, 8'h12); poke(32'h1FE, 8'hAA); poke(32'h1FF, 8'hAA);
    poke(32'h200, 8'hBB); poke(32'h201, 8'hBB); poke(32'h202, 8'h78); poke(32'h203, 8'h56);
    run(1'b0, 2'b11, 1'b0, 32'h1FE, 32'h0, 0, 1);
    if (SPLIT) begin
      chk("lw_split_rdata", o_rd, 32'hBBBB_AAAA);
      chk("lw_split_be1", 32'(o_be[1]), 32'b0011);
    end else begin
      chk("lw_mis_err", 32'(o_err), 32'd1);
      chk("lw_mis_lat", 32'(o_lat), 32'd1);
    end
    // beat address wraps at the top of the address space
    run(1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0, 0, 0);
    run(1'b1, 2'b00, 1'b0, 32'h0000_0040, 32'h1234_5678, 0, 0);
    // reset while the first beat is outstanding
    req_valid = 1'b1; memwrite = 1'b0; size = 2'b11; addr = 32'h300;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_pre_req", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_bus_req", 32'(bus_req), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_resp", {30'd0, resp_valid, bus_req}, 32'd0);
    end
    bus_ack = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom;
      if (i % 4 == 0) a[1:0] = 2'b11;
      run(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
